// File: rtl/rf_wb_scheduler_pkg.sv
// Shared definitions for the register-file write-back scheduler:
// FSM state encoding, round-robin requester IDs and default geometry.
package rf_wb_scheduler_pkg;

   localparam int NREG_DEF = 8;
   localparam int AW_DEF   = 3;
   localparam int DW_DEF   = 32;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_INIT = 1'b1
   } state_e;

   typedef enum logic {
      RR_A = 1'b0,
      RR_B = 1'b1
   } rr_e;

endpackage

// File: rtl/rf_rr_arb2.sv
// Two-requester round-robin arbiter (req[0] = ALU, req[1] = load).
// A lone requester always wins; on contention the one not served last wins.
// The rr_last flop only moves on an actual contest, and not while blocked.
module rf_rr_arb2
   import rf_wb_scheduler_pkg::*;
(
   input  logic       clk,
   input  logic       cr,
   input  logic [1:0] req,
   input  logic       block,
   output logic [1:0] gnt
);

   rr_e rr_last_q;
   rr_e rr_last_d;

   // Grant decode and next value of the last-winner flop
   always_comb begin
      gnt[0]    = req[0] & ~block & (~req[1] | (rr_last_q == RR_B));
      gnt[1]    = req[1] & ~block & (~req[0] | (rr_last_q == RR_A));
      rr_last_d = rr_last_q;
      if ((&req) && !block) begin
         rr_last_d = gnt[0] ? RR_A : RR_B;
      end
   end

   // Last-winner register; reset favours A for the first contest
   always_ff @(posedge clk or negedge cr) begin
      if (!cr) begin
         rr_last_q <= RR_B;
      end else begin
         rr_last_q <= rr_last_d;
      end
   end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Write-back scheduler owning the single write port of the register file.
// Arbitrates ALU (A) and load (B) write-backs round-robin and sequences a
// zero-fill clear walk over all registers.
// Optional feature macro: RF_FWD_EN adds a combinational write-to-read
// forwarding mux (rd_addr_a/b, rf_qa/qb in, fwd_qa/qb out).
module rf_wb_scheduler
   import rf_wb_scheduler_pkg::*;
#(
   parameter int NREG          = NREG_DEF,
   parameter int AW            = AW_DEF,
   parameter int DW            = DW_DEF,
   parameter int INIT_ON_RESET = 1
) (
   input  logic          clk,
   input  logic          cr,
   input  logic          a_valid,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_data,
   output logic          a_ready,
   input  logic          b_valid,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_data,
   output logic          b_ready,
   input  logic          init_req,
   output logic          busy,
   output logic          init_done,
   output logic          rf_we,
   output logic [AW-1:0] rf_addr,
   output logic [DW-1:0] rf_di
`ifdef RF_FWD_EN
   ,
   input  logic [AW-1:0] rd_addr_a,
   input  logic [AW-1:0] rd_addr_b,
   input  logic [DW-1:0] rf_qa,
   input  logic [DW-1:0] rf_qb,
   output logic [DW-1:0] fwd_qa,
   output logic [DW-1:0] fwd_qb
`endif
);

   state_e        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] di_q, di_d;
   logic          done_q, done_d;
   logic          busy_q, busy_d;
   logic [1:0]    gnt;
   logic          arb_block;

   // Requesters are held off while walking or when a walk is being requested
   assign arb_block = init_req | (state_q == ST_INIT);

   rf_rr_arb2 u_arb (
      .clk   (clk),
      .cr    (cr),
      .req   ({b_valid, a_valid}),
      .block (arb_block),
      .gnt   (gnt)
   );

   assign a_ready   = gnt[0];
   assign b_ready   = gnt[1];
   assign rf_we     = we_q;
   assign rf_addr   = addr_q;
   assign rf_di     = di_q;
   assign init_done = done_q;
   assign busy      = busy_q;

   // Next-state logic: accepted request or walk step is staged for the write port
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      di_d    = di_q;
      done_d  = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (init_req) begin
               state_d = ST_INIT;
               cnt_d   = '0;
            end else if (gnt[0]) begin
               we_d   = 1'b1;
               addr_d = a_addr;
               di_d   = a_data;
            end else if (gnt[1]) begin
               we_d   = 1'b1;
               addr_d = b_addr;
               di_d   = b_data;
            end
         end
         ST_INIT: begin
            we_d   = 1'b1;
            addr_d = cnt_q;
            di_d   = '0;
            cnt_d  = cnt_q + AW'(1);
            if (cnt_q == AW'(NREG - 1)) begin
               state_d = ST_RUN;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_RUN;
      endcase
      // busy covers the walk including the cycle its last write is driven
      busy_d = (state_d == ST_INIT) | done_d;
   end

   // FSM, walk counter and registered write-port outputs
   always_ff @(posedge clk or negedge cr) begin
      if (!cr) begin
         state_q <= (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         di_q    <= '0;
         done_q  <= 1'b0;
         busy_q  <= (INIT_ON_RESET != 0);
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         di_q    <= di_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

`ifdef RF_FWD_EN
   // Bypass the register file's write-to-read latency for the write in flight
   always_comb begin
      fwd_qa = (we_q && (addr_q == rd_addr_a)) ? di_q : rf_qa;
      fwd_qb = (we_q && (addr_q == rd_addr_b)) ? di_q : rf_qb;
   end
`endif

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Self-checking bench for rf_wb_scheduler (default INIT_ON_RESET=1).
module tb_rf_wb_scheduler;

   localparam int NREG = 8;

   logic        clk = 1'b0;
   logic        cr;
   logic        a_valid, b_valid, init_req;
   logic [2:0]  a_addr, b_addr;
   logic [31:0] a_data, b_data;
   logic        a_ready, b_ready, busy, init_done, rf_we;
   logic [2:0]  rf_addr;
   logic [31:0] rf_di;
`ifdef RF_FWD_EN
   logic [2:0]  rd_addr_a, rd_addr_b;
   logic [31:0] rf_qa, rf_qb, fwd_qa, fwd_qb;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   // reference model state
   int          m_walk;
   bit          m_favor_b;
   logic        m_ra, m_rb;
   logic        m_we, m_done, m_busy;
   logic [2:0]  m_addr;
   logic [31:0] m_di;

   typedef struct {
      logic        av;
      logic [2:0]  aa;
      logic [31:0] ad;
      logic        bv;
      logic [2:0]  ba;
      logic [31:0] bd;
      logic        ra;
      logic        rb;
      logic        we;
      logic [2:0]  addr;
      logic [31:0] di;
   } vec_t;

   vec_t tbl[8];

   always #5 clk = ~clk;

   rf_wb_scheduler dut (
      .clk       (clk),
      .cr        (cr),
      .a_valid   (a_valid),
      .a_addr    (a_addr),
      .a_data    (a_data),
      .a_ready   (a_ready),
      .b_valid   (b_valid),
      .b_addr    (b_addr),
      .b_data    (b_data),
      .b_ready   (b_ready),
      .init_req  (init_req),
      .busy      (busy),
      .init_done (init_done),
      .rf_we     (rf_we),
      .rf_addr   (rf_addr),
      .rf_di     (rf_di)
`ifdef RF_FWD_EN
      ,
      .rd_addr_a (rd_addr_a),
      .rd_addr_b (rd_addr_b),
      .rf_qa     (rf_qa),
      .rf_qb     (rf_qb),
      .fwd_qa    (fwd_qa),
      .fwd_qb    (fwd_qb)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_walk    = NREG;
      m_favor_b = 1'b0;
      m_we      = 1'b0;
      m_addr    = '0;
      m_di      = '0;
      m_done    = 1'b0;
      m_busy    = 1'b1;
   endtask

   // who may write this cycle, from the arbitration rules
   task automatic model_eval(input logic av, input logic bv, input logic ir);
      if (m_walk > 0 || ir) begin
         m_ra = 1'b0;
         m_rb = 1'b0;
      end else if (av && bv) begin
         m_ra = !m_favor_b;
         m_rb = m_favor_b;
      end else begin
         m_ra = av;
         m_rb = bv;
      end
   endtask

   // what the write port must show one cycle later
   task automatic model_commit(input logic av, input logic [2:0] aa, input logic [31:0] ad,
                               input logic bv, input logic [2:0] ba, input logic [31:0] bd,
                               input logic ir);
      if (m_walk > 0) begin
         m_we   = 1'b1;
         m_addr = 3'(NREG - m_walk);
         m_di   = '0;
         m_done = (m_walk == 1);
         m_walk--;
      end else begin
         m_done = 1'b0;
         if (ir) begin
            m_we   = 1'b0;
            m_walk = NREG;
         end else if (m_ra) begin
            m_we = 1'b1; m_addr = aa; m_di = ad;
            if (bv) m_favor_b = 1'b1;
         end else if (m_rb) begin
            m_we = 1'b1; m_addr = ba; m_di = bd;
            if (av) m_favor_b = 1'b0;
         end else begin
            m_we = 1'b0;
         end
      end
      m_busy = (m_walk > 0) || m_done;
   endtask

   task automatic chk_regs();
      chk("rf_we",     {31'd0, rf_we},     {31'd0, m_we});
      chk("rf_addr",   {29'd0, rf_addr},   {29'd0, m_addr});
      chk("rf_di",     rf_di,              m_di);
      chk("init_done", {31'd0, init_done}, {31'd0, m_done});
      chk("busy",      {31'd0, busy},      {31'd0, m_busy});
   endtask

   // one clock: drive inputs, check handshake, advance model, check write port
   task automatic cycle(input logic av, input logic [2:0] aa, input logic [31:0] ad,
                        input logic bv, input logic [2:0] ba, input logic [31:0] bd,
                        input logic ir, output logic ra_s, output logic rb_s);
      a_valid = av; a_addr = aa; a_data = ad;
      b_valid = bv; b_addr = ba; b_data = bd;
      init_req = ir;
      #1;
      ra_s = a_ready;
      rb_s = b_ready;
      model_eval(av, bv, ir);
      chk("a_ready", {31'd0, ra_s}, {31'd0, m_ra});
      chk("b_ready", {31'd0, rb_s}, {31'd0, m_rb});
      model_commit(av, aa, ad, bv, ba, bd, ir);
      @(posedge clk);
      #2;
      chk_regs();
   endtask

   task automatic idle(output logic ra_s, output logic rb_s);
      cycle(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0, 1'b0, ra_s, rb_s);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      logic ra, rb;

      tbl[0] = '{1'b1, 3'd3, 32'hDEADBEEF, 1'b0, 3'd0, 32'd0,  1'b1, 1'b0, 1'b1, 3'd3, 32'hDEADBEEF};
      tbl[1] = '{1'b1, 3'd1, 32'd11,       1'b1, 3'd2, 32'd22, 1'b1, 1'b0, 1'b1, 3'd1, 32'd11};
      tbl[2] = '{1'b1, 3'd1, 32'd11,       1'b1, 3'd2, 32'd22, 1'b0, 1'b1, 1'b1, 3'd2, 32'd22};
      tbl[3] = '{1'b1, 3'd1, 32'd11,       1'b1, 3'd2, 32'd22, 1'b1, 1'b0, 1'b1, 3'd1, 32'd11};
      tbl[4] = '{1'b1, 3'd1, 32'd11,       1'b1, 3'd2, 32'd22, 1'b0, 1'b1, 1'b1, 3'd2, 32'd22};
      tbl[5] = '{1'b0, 3'd0, 32'd0,        1'b0, 3'd0, 32'd0,  1'b0, 1'b0, 1'b0, 3'd2, 32'd22};
      tbl[6] = '{1'b0, 3'd0, 32'd0,        1'b1, 3'd0, 32'd5,  1'b0, 1'b1, 1'b1, 3'd0, 32'd5};
      tbl[7] = '{1'b1, 3'd4, 32'd44,       1'b1, 3'd6, 32'd66, 1'b1, 1'b0, 1'b1, 3'd4, 32'd44};

      // reset held with requests pending
      cr = 1'b0;
      a_valid = 1'b1; a_addr = 3'd1; a_data = 32'd1;
      b_valid = 1'b1; b_addr = 3'd2; b_data = 32'd2;
      init_req = 1'b0;
`ifdef RF_FWD_EN
      rd_addr_a = '0; rd_addr_b = '0; rf_qa = '0; rf_qb = '0;
`endif
      model_reset();
      @(posedge clk); @(posedge clk); #2;
      chk_regs();
      chk("rst_a_ready", {31'd0, a_ready}, 32'd0);
      chk("rst_b_ready", {31'd0, b_ready}, 32'd0);
      cr = 1'b1;

      // clear walk after reset release
      for (int i = 0; i < NREG; i++) begin
         idle(ra, rb);
         chk("walk_addr", {29'd0, rf_addr}, i);
         chk("walk_done", {31'd0, init_done}, (i == NREG - 1) ? 32'd1 : 32'd0);
      end
      idle(ra, rb);
      chk("walk_busy_fall", {31'd0, busy}, 32'd0);

      // arbitration vectors
      for (int i = 0; i < 8; i++) begin
         cycle(tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].bv, tbl[i].ba, tbl[i].bd, 1'b0, ra, rb);
         chk($sformatf("vec%0d_a_ready", i), {31'd0, ra}, {31'd0, tbl[i].ra});
         chk($sformatf("vec%0d_b_ready", i), {31'd0, rb}, {31'd0, tbl[i].rb});
         chk($sformatf("vec%0d_we", i),      {31'd0, rf_we}, {31'd0, tbl[i].we});
         chk($sformatf("vec%0d_addr", i),    {29'd0, rf_addr}, {29'd0, tbl[i].addr});
         chk($sformatf("vec%0d_di", i),      rf_di, tbl[i].di);
      end

`ifdef RF_FWD_EN
      cycle(1'b1, 3'd6, 32'd77, 1'b0, 3'd0, 32'd0, 1'b0, ra, rb);
      rd_addr_a = 3'd6; rd_addr_b = 3'd2; rf_qa = 32'd123; rf_qb = 32'd9;
      #1;
      chk("fwd_qa_hit", fwd_qa, 32'd77);
      chk("fwd_qb_miss", fwd_qb, 32'd9);
      rd_addr_a = 3'd1;
      #1;
      chk("fwd_qa_miss", fwd_qa, 32'd123);
      idle(ra, rb);
      #1;
      rd_addr_a = 3'd6;
      #1;
      chk("fwd_qa_no_we", fwd_qa, 32'd123);
`endif

      // A accept, then init_req while both request; second init_req mid-walk ignored
      cycle(1'b1, 3'd5, 32'h55, 1'b0, 3'd0, 32'd0, 1'b0, ra, rb);
      chk("pre_init_addr5", {29'd0, rf_addr}, 32'd5);
      cycle(1'b1, 3'd5, 32'h55, 1'b1, 3'd7, 32'h77, 1'b1, ra, rb);
      chk("init_req_a_ready", {31'd0, ra}, 32'd0);
      chk("init_req_b_ready", {31'd0, rb}, 32'd0);
      for (int i = 0; i < NREG; i++) begin
         cycle(1'b1, 3'd5, 32'h55, 1'b1, 3'd7, 32'h77, (i == 3), ra, rb);
         chk("walk2_addr", {29'd0, rf_addr}, i);
         chk("walk2_di", rf_di, 32'd0);
      end
      idle(ra, rb);

      // asynchronous reset at walk cycle 4
      cycle(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0, 1'b1, ra, rb);
      for (int i = 0; i < 4; i++) idle(ra, rb);
      cr = 1'b0;
      #1;
      chk("abort_we",   {31'd0, rf_we}, 32'd0);
      chk("abort_addr", {29'd0, rf_addr}, 32'd0);
      chk("abort_di",   rf_di, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd1);
      model_reset();
      @(posedge clk); #2;
      chk_regs();
      cr = 1'b1;
      idle(ra, rb);
      chk("restart_addr0", {29'd0, rf_addr}, 32'd0);
      chk("restart_we",    {31'd0, rf_we}, 32'd1);
      for (int i = 1; i < NREG + 1; i++) idle(ra, rb);

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
               1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
               ($urandom_range(0, 39) == 0), ra, rb);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
